// File: rtl/chunked_serial_adder_if.sv
// chunked_serial_adder_if: operand/result valid-ready bundle for chunked_serial_adder.
// The ovf signal exists only when ADDER_OVF_EN is defined.
interface chunked_serial_adder_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             c_out;
  logic             busy;
`ifdef ADDER_OVF_EN
  logic             ovf;
  modport master (output in_valid, a, b, c_in, out_ready,
                  input in_ready, out_valid, s, c_out, busy, ovf);
  modport slave  (input in_valid, a, b, c_in, out_ready,
                  output in_ready, out_valid, s, c_out, busy, ovf);
`else
  modport master (output in_valid, a, b, c_in, out_ready,
                  input in_ready, out_valid, s, c_out, busy);
  modport slave  (input in_valid, a, b, c_in, out_ready,
                  output in_ready, out_valid, s, c_out, busy);
`endif
endinterface

// File: rtl/chunked_serial_adder.sv
// chunked_serial_adder: s = a + b + c_in over WIDTH bits, CHUNK bits per clock.
// Define ADDER_OVF_EN to add the signed-overflow output ovf.
module chunked_serial_adder #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input logic clk,
  input logic rst_n,
  chunked_serial_adder_if.slave bus
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
  if (CHUNK < 1 || WIDTH % CHUNK != 0) begin : g_bad_cfg
    $fatal(1, "chunked_serial_adder: WIDTH must be a positive multiple of CHUNK");
  end
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           r_state;
  logic [IW-1:0]    r_idx;
  logic             r_carry;
  logic             r_c_out;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_s;
  logic [CHUNK:0]   w_sum;
  logic             w_last;
  assign w_sum  = {1'b0, r_a[r_idx*CHUNK +: CHUNK]} + {1'b0, r_b[r_idx*CHUNK +: CHUNK]}
                + (CHUNK+1)'(r_carry);
  assign w_last = r_idx == IW'(NCHUNK - 1);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_carry     <= 1'b0;
      r_s         <= '0;
      r_c_out     <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (bus.in_valid) begin
          r_a     <= bus.a;
          r_b     <= bus.b;
          r_carry <= bus.c_in;
          r_idx   <= '0;
          r_s     <= '0;
          r_state <= RUN;
        end
        RUN: begin
          r_s[r_idx*CHUNK +: CHUNK] <= w_sum[CHUNK-1:0];
          r_carry <= w_sum[CHUNK];
          r_idx   <= r_idx + 1'b1;
          if (w_last) begin
            r_c_out     <= w_sum[CHUNK];
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: if (bus.out_ready) begin
          r_out_valid <= 1'b0;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
`ifdef ADDER_OVF_EN
  logic r_ovf;
  // Carry into the MSB is recovered from the MSB sum bit of the final slice.
  always_ff @(posedge clk) begin
    if (!rst_n) r_ovf <= 1'b0;
    else if (r_state == RUN && w_last)
      r_ovf <= w_sum[CHUNK-1] ^ r_a[WIDTH-1] ^ r_b[WIDTH-1] ^ w_sum[CHUNK];
  end
  assign bus.ovf = r_ovf;
`endif
  assign bus.in_ready  = r_state == IDLE;
  assign bus.busy      = r_state != IDLE;
  assign bus.out_valid = r_out_valid;
  assign bus.s         = r_s;
  assign bus.c_out     = r_c_out;
endmodule

// File: tb/tb_chunked_serial_adder.sv
// tb_chunked_serial_adder: directed and exhaustive checks of chunked_serial_adder (8/2, 4/2, 4/1).
// Overflow checks are included when ADDER_OVF_EN is defined.
module tb_chunked_serial_adder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  chunked_serial_adder_if #(.WIDTH(8)) b8();
  chunked_serial_adder_if #(.WIDTH(4)) b42();
  chunked_serial_adder_if #(.WIDTH(4)) b41();
  chunked_serial_adder #(.WIDTH(8), .CHUNK(2)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));
  chunked_serial_adder #(.WIDTH(4), .CHUNK(2)) dut42 (.clk(clk), .rst_n(rst_n), .bus(b42));
  chunked_serial_adder #(.WIDTH(4), .CHUNK(1)) dut41 (.clk(clk), .rst_n(rst_n), .bus(b41));
  logic sel, v4, c4, r4;
  logic [3:0] a4, b4;
  logic w_rdy4, w_ov4, w_c4, w_busy4;
  logic [3:0] w_s4;
  assign b42.in_valid  = v4 & ~sel;
  assign b41.in_valid  = v4 & sel;
  assign b42.out_ready = r4 & ~sel;
  assign b41.out_ready = r4 & sel;
  assign b42.a = a4;
  assign b41.a = a4;
  assign b42.b = b4;
  assign b41.b = b4;
  assign b42.c_in = c4;
  assign b41.c_in = c4;
  assign w_rdy4  = sel ? b41.in_ready : b42.in_ready;
  assign w_ov4   = sel ? b41.out_valid : b42.out_valid;
  assign w_c4    = sel ? b41.c_out : b42.c_out;
  assign w_s4    = sel ? b41.s : b42.s;
  assign w_busy4 = sel ? b41.busy : b42.busy;
  int n_cmp = 0;
  int n_err = 0;
  logic [9:0] q[$];
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask
  function automatic logic [9:0] model8(input logic [7:0] a, input logic [7:0] b, input logic c);
    logic [8:0] u;
    int sv;
    u  = {1'b0, a} + {1'b0, b} + {8'd0, c};
    sv = int'($signed(a)) + int'($signed(b)) + int'(c);
    return {(sv > 127 || sv < -128), u};
  endfunction
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c, input int hold);
    logic [9:0] e;
    int t;
    q.push_back(model8(a, b, c));
    b8.a = a; b8.b = b; b8.c_in = c; b8.in_valid = 1'b1;
    t = 0;
    while (!b8.in_ready && t < 50) begin @(posedge clk); #1; t++; end
    check("accept_ready", b8.in_ready, 1);
    @(posedge clk); #1;
    b8.in_valid = hold > 0; b8.a = ~a; b8.b = 8'($urandom); b8.c_in = ~c;
    t = 0;
    while (!b8.out_valid && t < 50) begin @(posedge clk); #1; t++; end
    check("latency", t, 4);
    e = q.pop_front();
    for (int i = 0; i < hold; i++) begin
      check("hold_s", b8.s, e[7:0]);
      check("hold_c_out", b8.c_out, e[8]);
      check("hold_flags", {b8.out_valid, b8.in_ready}, 2'b10);
      @(posedge clk); #1;
    end
    check("sum", b8.s, e[7:0]);
    check("c_out", b8.c_out, e[8]);
`ifdef ADDER_OVF_EN
    check("ovf", b8.ovf, e[9]);
`endif
    b8.in_valid = 1'b0; b8.out_ready = 1'b1;
    @(posedge clk); #1;
    b8.out_ready = 1'b0;
    check("idle_after_take", {b8.out_valid, b8.in_ready}, 2'b01);
  endtask
  initial begin
    logic [9:0] e;
    logic [8:0] iv;
    logic acc, cons;
    int i, cyc, nacc, nch;
    int acc_cyc[4];
    b8.in_valid = 1'b0; b8.out_ready = 1'b0; b8.a = '0; b8.b = '0; b8.c_in = 1'b0;
    sel = 1'b0; v4 = 1'b0; r4 = 1'b0; a4 = '0; b4 = '0; c4 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", b8.out_valid, 0);
    check("rst_in_ready", b8.in_ready, 1);
    check("rst_busy", b8.busy, 0);
    check("rst_s", b8.s, 0);
    check("rst_c_out", b8.c_out, 0);
    rst_n = 1'b1;
    op8(8'hFF, 8'h01, 1'b0, 0);
    op8(8'hA5, 8'h5A, 1'b1, 0);
    op8(8'h12, 8'h34, 1'b0, 0);
    op8(8'h33, 8'hCC, 1'b1, 5);
    b8.a = 8'h77; b8.b = 8'h11; b8.c_in = 1'b1; b8.in_valid = 1'b1;
    @(posedge clk); #1;
    b8.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("run_busy", b8.busy, 1);
    rst_n = 1'b0; b8.in_valid = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1; b8.in_valid = 1'b0;
    check("mid_rst_s", b8.s, 0);
    check("mid_rst_c_out", b8.c_out, 0);
    check("mid_rst_out_valid", b8.out_valid, 0);
    check("mid_rst_in_ready", b8.in_ready, 1);
    op8(8'h0F, 8'h01, 1'b0, 0);
    op8(8'h7F, 8'h01, 1'b0, 0);
    op8(8'h80, 8'h80, 1'b0, 0);
    op8(8'h10, 8'h20, 1'b0, 0);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      nch = sel ? 4 : 2;
      i = 0; cyc = 0;
      iv = 9'(i);
      {c4, b4, a4} = iv; v4 = 1'b1; r4 = 1'($urandom_range(0, 1));
      while ((i < 512 || q.size() > 0) && cyc < 20000) begin
        acc = v4 && w_rdy4;
        cons = w_ov4 && r4;
        if (cons) begin
          if (q.size() == 0) check("unexpected_out4", 1, 0);
          else begin
            e = q.pop_front();
            check("sum4", {w_c4, w_s4}, e[4:0]);
          end
        end
        @(posedge clk); #1;
        cyc++;
        if (acc) begin
          q.push_back({5'd0, {1'b0, a4} + {1'b0, b4} + {4'd0, c4}});
          i++;
        end
        iv = 9'(i);
        {c4, b4, a4} = iv; v4 = i < 512; r4 = 1'($urandom_range(0, 1));
      end
      check("drain4", q.size(), 0);
      check("ops4", i, 512);
      r4 = 1'b1; v4 = 1'b1; nacc = 0; cyc = 0;
      while (nacc < 4 && cyc < 200) begin
        acc = v4 && w_rdy4;
        @(posedge clk); #1;
        cyc++;
        if (acc) begin acc_cyc[nacc] = cyc; nacc++; end
      end
      check("period_accepts", nacc, 4);
      for (int k = 1; k < 4; k++) check("period", acc_cyc[k] - acc_cyc[k-1], nch + 2);
      v4 = 1'b0;
      repeat (nch + 3) @(posedge clk);
      #1;
      check("idle4_busy", w_busy4, 0);
      r4 = 1'b0;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
